// File: rtl/game_pkg.sv
// Shared game constants, FSM state encoding and score helper for the score keeper.
package game_pkg;

  localparam int SCORE_W = 2;
  localparam int COORD_W = 12;
  localparam int HOLD_W  = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Saturating increment: a score never wraps past SCORE_MAX.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    r = (s == SCORE_MAX) ? s : s + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-side signal bundle: puck/vsync/restart inputs, score/win/strobe outputs, FSM state for debug.
interface score_keeper_if;
  import game_pkg::*;

  logic               vsync_in;
  logic [COORD_W-1:0] puck_x;
  logic [COORD_W-1:0] puck_y;
  logic               game_restart;
  logic [SCORE_W-1:0] player_1_point;
  logic [SCORE_W-1:0] player_2_point;
  logic               player_1_win;
  logic               player_2_win;
  logic               goal_pulse;
  logic               puck_reset;
  state_e             dbg_state;

  modport slave (
    input  vsync_in, puck_x, puck_y, game_restart,
    output player_1_point, player_2_point, player_1_win, player_2_win,
           goal_pulse, puck_reset, dbg_state
  );

  modport master (
    output vsync_in, puck_x, puck_y, game_restart,
    input  player_1_point, player_2_point, player_1_win, player_2_win,
           goal_pulse, puck_reset, dbg_state
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Registers vsync_in and emits a one-cycle frame_tick after each registered 0->1 transition.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic frame_tick
);

  logic vs_q, vs_d;
  logic vs_prev_q, vs_prev_d;
  logic armed_q, armed_d;

  // On the first edge after reset both stages load the live input, so a
  // vsync already high at release is not mistaken for a rising edge.
  always_comb begin
    vs_d      = vsync_in;
    vs_prev_d = armed_q ? vs_q : vsync_in;
    armed_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
      armed_q   <= armed_d;
    end
  end

  assign frame_tick = vs_q & ~vs_prev_q;

endmodule

// File: rtl/score_keeper.sv
// Goal detection, score/win tracking and post-goal freeze for a two-player puck game.
module score_keeper
  import game_pkg::*;
#(
  parameter logic [COORD_W-1:0] GOAL_LEFT_X  = 12'd40,
  parameter logic [COORD_W-1:0] GOAL_RIGHT_X = 12'd984,
  parameter logic [COORD_W-1:0] GOAL_YMIN    = 12'd300,
  parameter logic [COORD_W-1:0] GOAL_YMAX    = 12'd468,
  parameter logic [HOLD_W-1:0]  HOLD_FRAMES  = 8'd60
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);

  logic frame_tick;
  logic in_window;
  logic goal_right;
  logic goal_left;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic               win1_q, win1_d;
  logic               win2_q, win2_d;
  logic               goal_pulse_q, goal_pulse_d;
  logic               puck_reset_q, puck_reset_d;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .vsync_in   (bus.vsync_in),
    .frame_tick (frame_tick)
  );

  assign in_window  = (bus.puck_y >= GOAL_YMIN) && (bus.puck_y <= GOAL_YMAX);
  assign goal_right = in_window && (bus.puck_x >= GOAL_RIGHT_X);
  assign goal_left  = in_window && (bus.puck_x <= GOAL_LEFT_X);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    win1_d       = win1_q;
    win2_d       = win2_q;
    goal_pulse_d = 1'b0;

    if (bus.game_restart) begin
      state_d = ST_PLAY;
      hold_d  = '0;
      p1_d    = '0;
      p2_d    = '0;
      win1_d  = 1'b0;
      win2_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_tick && (goal_right || goal_left)) begin
            goal_pulse_d = 1'b1;
            hold_d       = HOLD_FRAMES;
            // Right goal wins a tie: player 1 is credited, player 2 ignored.
            if (goal_right) p1_d = score_inc(p1_q);
            else            p2_d = score_inc(p2_q);
            if (p1_d == SCORE_MAX) begin
              win1_d  = 1'b1;
              state_d = ST_OVER;
            end else if (p2_d == SCORE_MAX) begin
              win2_d  = 1'b1;
              state_d = ST_OVER;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // A count of 0 or 1 expires on this tick, covering HOLD_FRAMES = 0.
          if (frame_tick) begin
            if (hold_q <= 8'd1) begin
              hold_d  = '0;
              state_d = ST_PLAY;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end

    puck_reset_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_PLAY;
      hold_q       <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      win1_q       <= 1'b0;
      win2_q       <= 1'b0;
      goal_pulse_q <= 1'b0;
      puck_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      win1_q       <= win1_d;
      win2_q       <= win2_d;
      goal_pulse_q <= goal_pulse_d;
      puck_reset_q <= puck_reset_d;
    end
  end

  assign bus.player_1_point = p1_q;
  assign bus.player_2_point = p2_q;
  assign bus.player_1_win   = win1_q;
  assign bus.player_2_win   = win2_q;
  assign bus.goal_pulse     = goal_pulse_q;
  assign bus.puck_reset     = puck_reset_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: goals, window edges, freeze length, win/over, restart and async reset.
module tb_score_keeper;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  score_keeper_if bus ();
  score_keeper_if bus0 ();

  score_keeper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance with a zero-length freeze, fed the same inputs.
  score_keeper #(.HOLD_FRAMES(8'd0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.vsync_in     = bus.vsync_in;
  assign bus0.puck_x       = bus.puck_x;
  assign bus0.puck_y       = bus.puck_y;
  assign bus0.game_restart = bus.game_restart;

  // One frame: vsync high for two cycles, eight cycles total; counts goal_pulse cycles.
  task automatic do_frame(input logic [11:0] x, input logic [11:0] y, output int pulses);
    pulses = 0;
    bus.puck_x   = x;
    bus.puck_y   = y;
    bus.vsync_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.goal_pulse === 1'b1) pulses++;
      if (i == 1) bus.vsync_in = 1'b0;
    end
  endtask

  // Frame in which game_restart coincides with the sampling tick.
  task automatic restart_on_tick(input logic [11:0] x, input logic [11:0] y, output int pulses);
    pulses = 0;
    bus.puck_x   = x;
    bus.puck_y   = y;
    bus.vsync_in = 1'b1;
    @(negedge clk);
    bus.game_restart = 1'b1;
    @(negedge clk);
    bus.game_restart = 1'b0;
    bus.vsync_in     = 1'b0;
    if (bus.goal_pulse === 1'b1) pulses++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.goal_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.vsync_in = 1'b0;
    bus.puck_x = 12'd500;
    bus.puck_y = 12'd400;
    bus.game_restart = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.player_1_point, bus.player_2_point} !== 4'b0) begin
      failures++; $display("FAIL reset_scores actual=%b expected=0000", {bus.player_1_point, bus.player_2_point});
    end
    checks++;
    if ({bus.player_1_win, bus.player_2_win, bus.goal_pulse, bus.puck_reset} !== 4'b0) begin
      failures++; $display("FAIL reset_flags actual=%b expected=0000",
                           {bus.player_1_win, bus.player_2_win, bus.goal_pulse, bus.puck_reset});
    end
    checks++;
    if (bus.dbg_state !== ST_PLAY) begin
      failures++; $display("FAIL reset_state actual=%0d expected=%0d", bus.dbg_state, ST_PLAY);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_outside_window();
    logic [11:0] xs [4];
    logic [11:0] ys [4];
    int p;
    xs = '{12'd990, 12'd990, 12'd41, 12'd983};
    ys = '{12'd200, 12'd299, 12'd400, 12'd400};
    for (int i = 0; i < 4; i++) begin
      do_frame(xs[i], ys[i], p);
      checks++;
      if (p !== 0 || bus.player_1_point !== 2'd0 || bus.player_2_point !== 2'd0 || bus.dbg_state !== ST_PLAY) begin
        failures++;
        $display("FAIL no_goal_%0d actual pulses=%0d p1=%0d p2=%0d st=%0d expected 0/0/0/PLAY",
                 i, p, bus.player_1_point, bus.player_2_point, bus.dbg_state);
      end
    end
  endtask

  task automatic test_right_goal();
    int p;
    int frames;
    do_frame(12'd990, 12'd400, p);
    checks++;
    if (p !== 1) begin failures++; $display("FAIL goal_pulse_count actual=%0d expected=1", p); end
    checks++;
    if (bus.player_1_point !== 2'd1) begin
      failures++; $display("FAIL goal_p1 actual=%0d expected=1", bus.player_1_point);
    end
    checks++;
    if (bus.puck_reset !== 1'b1 || bus.dbg_state !== ST_HOLD) begin
      failures++; $display("FAIL goal_hold actual puck_reset=%b st=%0d expected 1/HOLD", bus.puck_reset, bus.dbg_state);
    end
    checks++;
    if (bus0.dbg_state !== ST_HOLD) begin
      failures++; $display("FAIL hold0_enter actual=%0d expected=%0d", bus0.dbg_state, ST_HOLD);
    end
    do_frame(12'd500, 12'd400, p);
    frames = 1;
    checks++;
    if (bus0.dbg_state !== ST_PLAY) begin
      failures++; $display("FAIL hold0_exit actual=%0d expected=%0d", bus0.dbg_state, ST_PLAY);
    end
    while (bus.dbg_state !== ST_PLAY && frames < 70) begin
      do_frame(12'd500, 12'd400, p);
      frames++;
    end
    checks++;
    if (frames !== 60) begin failures++; $display("FAIL hold_frames actual=%0d expected=60", frames); end
    checks++;
    if (bus.puck_reset !== 1'b0) begin failures++; $display("FAIL hold_release actual=%b expected=0", bus.puck_reset); end
  endtask

  task automatic test_held_in_mouth();
    int p;
    int total;
    do_frame(12'd984, 12'd468, p);
    checks++;
    if (p !== 1 || bus.player_1_point !== 2'd2) begin
      failures++; $display("FAIL edge_goal actual pulses=%0d p1=%0d expected 1/2", p, bus.player_1_point);
    end
    total = 0;
    for (int i = 0; i < 60; i++) begin
      do_frame(12'd984, 12'd468, p);
      total += p;
    end
    checks++;
    if (total !== 0 || bus.player_1_point !== 2'd2 || bus.dbg_state !== ST_PLAY) begin
      failures++; $display("FAIL held_hold actual pulses=%0d p1=%0d st=%0d expected 0/2/PLAY",
                           total, bus.player_1_point, bus.dbg_state);
    end
    do_frame(12'd984, 12'd468, p);
    checks++;
    if (p !== 1 || bus.player_1_point !== 2'd3 || bus.player_1_win !== 1'b1) begin
      failures++; $display("FAIL third_goal actual pulses=%0d p1=%0d win1=%b expected 1/3/1",
                           p, bus.player_1_point, bus.player_1_win);
    end
    checks++;
    if (bus.dbg_state !== ST_OVER || bus.puck_reset !== 1'b1 || bus.player_2_win !== 1'b0) begin
      failures++; $display("FAIL over_enter actual st=%0d puck_reset=%b win2=%b expected OVER/1/0",
                           bus.dbg_state, bus.puck_reset, bus.player_2_win);
    end
  endtask

  task automatic test_over_freeze();
    int p;
    do_frame(12'd40, 12'd400, p);
    checks++;
    if (p !== 0 || bus.player_2_point !== 2'd0 || bus.player_1_win !== 1'b1 || bus.dbg_state !== ST_OVER) begin
      failures++; $display("FAIL over_left actual pulses=%0d p2=%0d win1=%b st=%0d expected 0/0/1/OVER",
                           p, bus.player_2_point, bus.player_1_win, bus.dbg_state);
    end
    do_frame(12'd990, 12'd400, p);
    checks++;
    if (p !== 0 || bus.player_1_point !== 2'd3) begin
      failures++; $display("FAIL over_right actual pulses=%0d p1=%0d expected 0/3", p, bus.player_1_point);
    end
  endtask

  task automatic test_restart();
    int p;
    restart_on_tick(12'd990, 12'd400, p);
    checks++;
    if ({bus.player_1_point, bus.player_2_point, bus.player_1_win, bus.player_2_win} !== 6'b0) begin
      failures++; $display("FAIL restart_over_clear actual=%b expected=000000",
                           {bus.player_1_point, bus.player_2_point, bus.player_1_win, bus.player_2_win});
    end
    checks++;
    if (bus.dbg_state !== ST_PLAY || bus.puck_reset !== 1'b0 || p !== 0) begin
      failures++; $display("FAIL restart_over_state actual st=%0d puck_reset=%b pulses=%0d expected PLAY/0/0",
                           bus.dbg_state, bus.puck_reset, p);
    end
    restart_on_tick(12'd990, 12'd400, p);
    checks++;
    if (p !== 0 || bus.player_1_point !== 2'd0 || bus.dbg_state !== ST_PLAY) begin
      failures++; $display("FAIL restart_priority actual pulses=%0d p1=%0d st=%0d expected 0/0/PLAY",
                           p, bus.player_1_point, bus.dbg_state);
    end
  endtask

  task automatic test_async_reset();
    int p;
    do_frame(12'd40, 12'd300, p);
    checks++;
    if (p !== 1 || bus.player_2_point !== 2'd1 || bus.dbg_state !== ST_HOLD) begin
      failures++; $display("FAIL left_goal actual pulses=%0d p2=%0d st=%0d expected 1/1/HOLD",
                           p, bus.player_2_point, bus.dbg_state);
    end
    for (int i = 0; i < 3; i++) do_frame(12'd500, 12'd400, p);
    bus.puck_x   = 12'd990;
    bus.puck_y   = 12'd400;
    bus.vsync_in = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.player_2_point !== 2'd0 || bus.puck_reset !== 1'b0 || bus.dbg_state !== ST_PLAY) begin
      failures++; $display("FAIL async_reset actual p2=%0d puck_reset=%b st=%0d expected 0/0/PLAY",
                           bus.player_2_point, bus.puck_reset, bus.dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.goal_pulse === 1'b1) p++;
    end
    checks++;
    if (p !== 0 || bus.player_1_point !== 2'd0) begin
      failures++; $display("FAIL release_no_edge actual pulses=%0d p1=%0d expected 0/0", p, bus.player_1_point);
    end
    bus.vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    do_frame(12'd990, 12'd400, p);
    checks++;
    if (p !== 1 || bus.player_1_point !== 2'd1) begin
      failures++; $display("FAIL post_reset_goal actual pulses=%0d p1=%0d expected 1/1", p, bus.player_1_point);
    end
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_outside_window();
    test_right_goal();
    test_held_in_mouth();
    test_over_freeze();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter GOAL_LEFT_X, default 12'd40; puck_x at or below this value is a left-goal condition.
REQ-002 Parameter GOAL_RIGHT_X, default 12'd984; puck_x at or above this value is a right-goal condition.
REQ-003 Parameters GOAL_YMIN, default 12'd300, and GOAL_YMAX, default 12'd468; inclusive goal-mouth window on puck_y.
REQ-004 Parameter HOLD_FRAMES, default 8'd60; length of the post-goal freeze, in frames.
REQ-005 clk  in  1  system (pixel) clock; all state is updated on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 vsync_in  in  1  timing vsync; each rising edge marks a frame boundary.
REQ-008 puck_x, puck_y  in  12 each  puck centre position, stable across a frame.
REQ-009 game_restart  in  1  single-cycle request to start a new match.
REQ-010 player_1_point, player_2_point  out  2 each  registered scores, 0..3.
REQ-011 player_1_win, player_2_win  out  1 each  held high while that player has won.
REQ-012 goal_pulse  out  1  one-cycle strobe issued on every scored goal.
REQ-013 puck_reset  out  1  held high throughout the post-goal freeze; the puck block recentres the puck while it is high.

Function
REQ-014 frame_tick SHALL be a one-cycle pulse asserted on the cycle after a 0->1 transition of registered vsync_in.
REQ-015 A right-goal condition SHALL be: puck_x >= GOAL_RIGHT_X and GOAL_YMIN <= puck_y <= GOAL_YMAX; it credits player 1.
REQ-016 A left-goal condition SHALL be: puck_x <= GOAL_LEFT_X with the same y window; it credits player 2.
REQ-017 Goal conditions SHALL be sampled only on frame_tick; puck inputs are ignored on all other cycles.
REQ-018 The FSM SHALL have three states: PLAY, HOLD and OVER. The reset state is PLAY.
REQ-019 PLAY, on a frame_tick with a goal condition:
- increment the credited score (2-bit, never wraps);
- assert goal_pulse on the next cycle;
- load the hold counter with HOLD_FRAMES;
- go to HOLD, or go to OVER if the new score is 3.
REQ-020 If both goal conditions are true on the same tick, player 1 SHALL be credited and player 2 ignored.
REQ-021 HOLD SHALL decrement the hold counter on each frame_tick and return to PLAY on the tick on which the counter reaches 0; no goal is scored while in HOLD.
REQ-022 puck_reset SHALL be 1 in HOLD and in OVER, and 0 in PLAY.
REQ-023 OVER SHALL keep the win flag of the player whose score is 3 asserted and freeze both scores; further goal conditions are ignored.
REQ-024 game_restart SHALL take effect on the next clock edge in every state:
- clear both scores, both win flags and the hold counter;
- go to PLAY;
- take priority over a goal sampled on the same cycle.
REQ-025 Latency: a goal sampled on frame_tick at cycle N SHALL update the score and goal_pulse at cycle N+1, and the win flag at cycle N+1.
REQ-026 HOLD_FRAMES = 0 SHALL return the FSM to PLAY on the first frame_tick in HOLD.

Reset
REQ-027 While rst = 0, the block SHALL hold:
- FSM in PLAY;
- scores = 2'b00;
- win flags = 0, goal_pulse = 0, puck_reset = 0;
- hold counter = 0, registered vsync = 0.
REQ-028 Reset assertion SHALL take effect immediately, without a clock, including in the middle of HOLD or OVER.
REQ-029 Reset release SHALL be followed by operation on the first clock edge; no vsync edge SHALL be inferred from the reset value.

Structure
REQ-030 The FSM state encoding and the score width/maximum constants SHALL live in the shared package game_pkg.
REQ-031 Vsync edge detection SHALL be a separate sub-module, frame_tick_gen, with ports clk, rst, vsync_in and frame_tick.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 puck (990, 400) on one frame_tick -> goal_pulse high for one cycle, player_1_point = 1, puck_reset high for 60 frames, then state PLAY.
REQ-034 puck (990, 200), outside the window -> no score change and no goal_pulse.
REQ-035 Three separate right goals -> player_1_point = 3, player_1_win = 1; a later left goal leaves player_2_point = 0.
REQ-036 game_restart pulsed in OVER, same cycle as a goal condition -> both scores 0, both win flags 0, state PLAY.
REQ-037 rst driven low mid-HOLD, asynchronous to clk -> outputs take reset values before the next clk edge.
REQ-038 Puck held in the goal mouth across the whole HOLD period -> exactly one score per HOLD exit.
